// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding, winner codes and default count width for the vote announcer.
package vote_pkg;
   localparam int VOTE_COUNT_W = 6;
   typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_SEND, ST_DONE} state_t;
   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_C1   = 2'd1;
   localparam logic [1:0] WIN_C2   = 2'd2;
   localparam logic [1:0] WIN_C3   = 2'd3;
endpackage

// File: rtl/vote_compare3.sv
// vote_compare3: combinational three-way winner/tie decision on unsigned counts.
module vote_compare3 import vote_pkg::*; #(
   parameter int COUNT_W = VOTE_COUNT_W
) (
   input  logic [COUNT_W-1:0] i_a,
   input  logic [COUNT_W-1:0] i_b,
   input  logic [COUNT_W-1:0] i_c,
   output logic [1:0]         o_winner,
   output logic               o_tie
);
   logic [COUNT_W-1:0] w_max_ab, w_max;
   logic               w_ea, w_eb, w_ec, w_zero, w_one;
   always_comb begin
      w_max_ab = (i_a >= i_b) ? i_a : i_b;
      w_max    = (w_max_ab >= i_c) ? w_max_ab : i_c;
      w_ea     = (i_a == w_max);
      w_eb     = (i_b == w_max);
      w_ec     = (i_c == w_max);
      w_zero   = (w_max == '0);
      w_one    = (w_ea ^ w_eb ^ w_ec) & ~(w_ea & w_eb & w_ec);
      o_winner = (w_zero || !w_one) ? WIN_NONE : w_ea ? WIN_C1 : w_eb ? WIN_C2 : WIN_C3;
      o_tie    = ~w_zero & ~w_one;
   end
endmodule

// File: rtl/vote_result_announcer.sv
// vote_result_announcer: snapshots tallies on a rising voting_over edge, decides the winner,
// then streams the three final counts over a valid/ready display channel.
module vote_result_announcer import vote_pkg::*; #(
   parameter int COUNT_W   = VOTE_COUNT_W,
   parameter int NUM_BEATS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_voting_over,
   input  logic [COUNT_W-1:0] i_count1,
   input  logic [COUNT_W-1:0] i_count2,
   input  logic [COUNT_W-1:0] i_count3,
   input  logic               i_disp_ready,
   output logic               o_result_valid,
   output logic [1:0]         o_winner,
   output logic               o_tie,
   output logic               o_disp_valid,
   output logic [1:0]         o_disp_id,
   output logic [COUNT_W-1:0] o_disp_count,
   output logic               o_done
);
   state_t             r_state, w_next;
   logic               r_vo_prev, r_result_valid, r_tie;
   logic [1:0]         r_winner, r_beat, w_cmp_winner;
   logic [COUNT_W-1:0] r_cnt1, r_cnt2, r_cnt3;
   logic               w_start, w_xfer, w_cmp_tie;
   vote_compare3 #(.COUNT_W(COUNT_W)) u_cmp (
      .i_a(r_cnt1), .i_b(r_cnt2), .i_c(r_cnt3),
      .o_winner(w_cmp_winner), .o_tie(w_cmp_tie)
   );
   always_comb begin
      w_start        = i_voting_over & ~r_vo_prev;
      w_xfer         = (r_state == ST_SEND) & i_disp_ready;
      w_next         = r_state == ST_IDLE ? (w_start ? ST_CMP : ST_IDLE)
                     : r_state == ST_CMP  ? ST_SEND
                     : r_state == ST_SEND ? ((w_xfer && r_beat == 2'(NUM_BEATS)) ? ST_DONE : ST_SEND)
                     : ST_DONE;
      o_disp_valid   = (r_state == ST_SEND);
      o_disp_id      = o_disp_valid ? r_beat : 2'd0;
      o_disp_count   = !o_disp_valid ? '0 : r_beat == 2'd1 ? r_cnt1 : r_beat == 2'd2 ? r_cnt2 : r_cnt3;
      o_done         = (r_state == ST_DONE);
      o_result_valid = r_result_valid;
      o_winner       = r_winner;
      o_tie          = r_tie;
   end
   // vo_prev resets high so a level already asserted through reset cannot start a run
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_vo_prev      <= 1'b1;
         r_cnt1         <= '0;
         r_cnt2         <= '0;
         r_cnt3         <= '0;
         r_result_valid <= 1'b0;
         r_winner       <= WIN_NONE;
         r_tie          <= 1'b0;
         r_beat         <= 2'd0;
      end else begin
         r_state   <= w_next;
         r_vo_prev <= i_voting_over;
         if (r_state == ST_IDLE && w_start) begin
            r_cnt1 <= i_count1;
            r_cnt2 <= i_count2;
            r_cnt3 <= i_count3;
         end
         if (r_state == ST_CMP) begin
            r_result_valid <= 1'b1;
            r_winner       <= w_cmp_winner;
            r_tie          <= w_cmp_tie;
            r_beat         <= 2'd1;
         end
         if (w_xfer) r_beat <= r_beat + 2'd1;
      end
   end
endmodule

// File: tb/tb_vote_result_announcer.sv
// tb_vote_result_announcer: directed scenarios plus randomized sessions checked against a
// behavioural max/tie model.
module tb_vote_result_announcer;
   localparam int W = 6;
   logic         clk = 1'b0, rst = 1'b1, vo = 1'b0, ready = 1'b0;
   logic [W-1:0] c1 = '0, c2 = '0, c3 = '0;
   logic         o_result_valid, o_tie, o_disp_valid, o_done;
   logic [1:0]   o_winner, o_disp_id;
   logic [W-1:0] o_disp_count;
   int           checks = 0, failures = 0;

   always #5 clk = ~clk;

   vote_result_announcer #(.COUNT_W(W), .NUM_BEATS(3)) dut (
      .clk(clk), .rst(rst), .i_voting_over(vo),
      .i_count1(c1), .i_count2(c2), .i_count3(c3), .i_disp_ready(ready),
      .o_result_valid(o_result_valid), .o_winner(o_winner), .o_tie(o_tie),
      .o_disp_valid(o_disp_valid), .o_disp_id(o_disp_id), .o_disp_count(o_disp_count),
      .o_done(o_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input int a, input int b, input int c, output int w, output int t);
      int v[3];
      int mx, n, idx;
      v = '{a, b, c};
      mx = 0; n = 0; idx = 0;
      foreach (v[i]) if (v[i] > mx) mx = v[i];
      foreach (v[i]) if (v[i] == mx) begin n++; idx = i + 1; end
      w = (mx != 0 && n == 1) ? idx : 0;
      t = (mx != 0 && n > 1) ? 1 : 0;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_rv"}, 32'(o_result_valid), 0);
      chk({tag, "_win"}, 32'(o_winner), 0);
      chk({tag, "_tie"}, 32'(o_tie), 0);
      chk({tag, "_dv"}, 32'(o_disp_valid), 0);
      chk({tag, "_id"}, 32'(o_disp_id), 0);
      chk({tag, "_cnt"}, 32'(o_disp_count), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle(tag);
   endtask

   // raise voting_over, scramble the inputs after the sampling edge, then check the result
   task automatic start(input string tag, input int a, input int b, input int c);
      int w, t;
      c1 = W'(a); c2 = W'(b); c3 = W'(c);
      vo = 1'b0;
      tick();
      vo = 1'b1;
      tick();
      c1 = W'($urandom); c2 = W'($urandom); c3 = W'($urandom);
      chk({tag, "_rv_cmp"}, 32'(o_result_valid), 0);
      chk({tag, "_dv_cmp"}, 32'(o_disp_valid), 0);
      tick();
      model(a, b, c, w, t);
      chk({tag, "_rv"}, 32'(o_result_valid), 1);
      chk({tag, "_win"}, 32'(o_winner), 32'(w));
      chk({tag, "_tie"}, 32'(o_tie), 32'(t));
   endtask

   task automatic stream(input string tag, input int a, input int b, input int c,
                         input int stall_beat, input int stall_len, input bit rnd);
      int v[3];
      int w, t, waited;
      bit sent;
      v = '{a, b, c};
      model(a, b, c, w, t);
      for (int bt = 1; bt <= 3; bt++) begin
         waited = 0;
         sent = 1'b0;
         while (!sent && waited < 64) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : ((bt == stall_beat && waited < stall_len) ? 1'b0 : 1'b1);
            chk({tag, "_dv"}, 32'(o_disp_valid), 1);
            chk({tag, "_id"}, 32'(o_disp_id), 32'(bt));
            chk({tag, "_cnt"}, 32'(o_disp_count), 32'(v[bt-1]));
            chk({tag, "_done_early"}, 32'(o_done), 0);
            sent = ready;
            tick();
            waited++;
         end
         if (!sent) chk({tag, "_timeout"}, 0, 1);
      end
      chk({tag, "_done"}, 32'(o_done), 1);
      chk({tag, "_dv_end"}, 32'(o_disp_valid), 0);
      chk({tag, "_rv_end"}, 32'(o_result_valid), 1);
      chk({tag, "_win_end"}, 32'(o_winner), 32'(w));
      chk({tag, "_tie_end"}, 32'(o_tie), 32'(t));
   endtask

   initial begin
      int a, b, c;
      do_reset("reset");
      // tie with two candidates on 3
      start("tie", 3, 3, 2);
      stream("tie", 3, 3, 2, 0, 0, 1'b0);
      // clear winner, later input changes and edges are ignored
      do_reset("r2");
      start("clear", 5, 2, 1);
      stream("clear", 5, 2, 1, 0, 0, 1'b0);
      c1 = 0; c2 = 9; c3 = 9;
      vo = 1'b0; tick(); vo = 1'b1; tick(); tick(); tick();
      chk("clear_hold_win", 32'(o_winner), 1);
      chk("clear_hold_tie", 32'(o_tie), 0);
      chk("clear_hold_done", 32'(o_done), 1);
      chk("clear_hold_dv", 32'(o_disp_valid), 0);
      // no votes
      do_reset("r3");
      start("zero", 0, 0, 0);
      stream("zero", 0, 0, 0, 0, 0, 1'b0);
      // backpressure on beat 2
      do_reset("r4");
      start("bp", 4, 7, 7);
      stream("bp", 4, 7, 7, 2, 4, 1'b0);
      // level held through reset must not trigger
      vo = 1'b1;
      do_reset("r5");
      tick(); tick(); tick();
      check_idle("lvl");
      start("lvl", 10, 20, 30);
      stream("lvl", 10, 20, 30, 0, 0, 1'b0);
      // reset while beat 2 is stalled, then restart with new counts
      do_reset("r6");
      start("mid", 8, 1, 2);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("mid_id_stall", 32'(o_disp_id), 2);
      chk("mid_cnt_stall", 32'(o_disp_count), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("mid_rst");
      start("mid2", 2, 6, 1);
      stream("mid2", 2, 6, 1, 0, 0, 1'b0);
      // randomized sessions, biased toward ties and the top count value
      for (int s = 0; s < 24; s++) begin
         do_reset("rr");
         case (s % 3)
            0: begin a = $urandom_range(0, 63); b = $urandom_range(0, 63); c = $urandom_range(0, 63); end
            1: begin a = $urandom_range(0, 2); b = $urandom_range(0, 2); c = $urandom_range(0, 2); end
            default: begin a = 63 - $urandom_range(0, 1); b = 63 - $urandom_range(0, 1); c = $urandom_range(0, 63); end
         endcase
         start("rnd", a, b, c);
         stream("rnd", a, b, c, 0, 0, 1'b1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
